log_arbiter: RTL and testbench

- Shares one multi-cycle `log` datapath instance (N_STAGE-term Taylor pipeline, 5.10 fixed point) between two requesters, e.g. two HSS feature channels.
- The log datapath reads its input combinationally in every stage, so it is not truly pipelined. Its input must therefore be held stable until the result has settled.
- This block arbitrates round-robin, drives and holds the datapath input, and waits the settle time. It then returns the result to the requester that issued it.
- Only one operation is in flight at a time.

---
 rtl/log_arbiter.sv | 123 ++++++++++++
 tb/tb_log_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_arbiter.sv
// Round-robin arbiter sharing one multi-cycle log datapath between two requesters.
// Holds the datapath operand stable for WAIT_CYC edges, then returns the result to the issuer.
module log_arbiter #(
    parameter int unsigned N_STAGE  = 2,
    parameter int unsigned WAIT_CYC = N_STAGE + 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [15:0] resp_data,
    output logic [15:0] log_data,
    input  logic [15:0] log_result,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(WAIT_CYC + 1);

    typedef enum logic [1:0] {StInit, StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [15:0]     log_data_q, log_data_d;
    logic [15:0]     resp_data_q, resp_data_d;
    logic            resp0_valid_q, resp0_valid_d;
    logic            resp1_valid_q, resp1_valid_d;
    logic            grant;
    logic            accept;

    // Contention goes to whoever was not served last.
    always_comb begin
        grant = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  state_d = StIdle;
            StIdle:  if (accept) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        req0_ready = !RST && (state_q == StIdle) && !grant && req0_valid;
        req1_ready = !RST && (state_q == StIdle) && grant && req1_valid;
        accept     = req0_ready || req1_ready;
        busy       = (state_q != StIdle);
    end

    always_comb begin
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        log_data_d    = log_data_q;
        resp_data_d   = resp_data_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        if (state_q == StIdle && accept) begin
            log_data_d   = grant ? req1_data : req0_data;
            owner_d      = grant;
            last_grant_d = grant;
            cnt_d        = CntW'(WAIT_CYC);
        end else if (state_q == StWait) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CntW'(1);
            end else begin
                resp_data_d   = log_result;
                resp0_valid_d = !owner_q;
                resp1_valid_d = owner_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q         <= '0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            log_data_q    <= '0;
            resp_data_q   <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            log_data_q    <= log_data_d;
            resp_data_q   <= resp_data_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign log_data    = log_data_q;
    assign resp_data   = resp_data_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;

endmodule

// File: tb/tb_log_arbiter.sv
// Bench for log_arbiter: two instances (N_STAGE=2 and 4) with a settle-time log stub,
// a timeline reference model checked every cycle, and directed literal expectations.
`timescale 1ns/1ps
module tb_log_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  vld   [2];
    logic [15:0] dat   [2][2];
    logic [1:0]  rdy   [2];
    logic [1:0]  rsp   [2];
    logic [15:0] rdata [2];
    logic [15:0] ldata [2];
    logic [15:0] lres  [2];
    logic        bsy   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    log_arbiter #(.N_STAGE(2)) u_dut0 (
        .CLK(CLK), .RST(RST),
        .req0_valid(vld[0][0]), .req0_data(dat[0][0]), .req0_ready(rdy[0][0]),
        .req1_valid(vld[0][1]), .req1_data(dat[0][1]), .req1_ready(rdy[0][1]),
        .resp0_valid(rsp[0][0]), .resp1_valid(rsp[0][1]), .resp_data(rdata[0]),
        .log_data(ldata[0]), .log_result(lres[0]), .busy(bsy[0])
    );

    log_arbiter #(.N_STAGE(4)) u_dut1 (
        .CLK(CLK), .RST(RST),
        .req0_valid(vld[1][0]), .req0_data(dat[1][0]), .req0_ready(rdy[1][0]),
        .req1_valid(vld[1][1]), .req1_data(dat[1][1]), .req1_ready(rdy[1][1]),
        .resp0_valid(rsp[1][0]), .resp1_valid(rsp[1][1]), .resp_data(rdata[1]),
        .log_data(ldata[1]), .log_result(lres[1]), .busy(bsy[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    task automatic chk(input string name, input int i, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d: got %h, expected %h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    // Log stub: garbage until WAIT_CYC edges have passed since its input last changed.
    int          age  [2] = '{100, 100};
    logic [15:0] prev [2] = '{16'h0000, 16'h0000};
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (ldata[i] != prev[i]) begin
                prev[i] <= ldata[i];
                age[i]  <= 1;
            end else if (age[i] < 100) begin
                age[i] <= age[i] + 1;
            end
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++) lres[i] = (age[i] >= wc(i)) ? ldata[i] + 16'd1 : 16'hDEAD;
    end

    // Reference model: an operation accepted at edge e answers at edge e+WAIT_CYC+1.
    int          cyc = 0;
    logic        started = 1'b0;
    logic        m_init   [2];
    logic        m_active [2];
    logic        m_owner  [2];
    logic        m_last   [2];
    int          m_done   [2];
    logic [15:0] m_log    [2];
    logic [15:0] m_resp   [2];
    logic [1:0]  m_pulse  [2];
    int          acc_c [2][1024];
    logic        acc_o [2][1024];
    int          n_acc [2] = '{0, 0};
    int          rsp_c [2][1024];
    logic        rsp_o [2][1024];
    logic [15:0] rsp_d [2][1024];
    int          n_rsp [2] = '{0, 0};

    function automatic logic [1:0] exp_rdy(input int i);
        logic g;
        if (RST || !started || m_init[i] || m_active[i]) return 2'b00;
        case (vld[i])
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            2'b11:   g = ~m_last[i];
            default: return 2'b00;
        endcase
        return g ? 2'b10 : 2'b01;
    endfunction

    always @(posedge CLK) begin
        logic [1:0] a;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            a = exp_rdy(i);
            m_pulse[i] = 2'b00;
            if (RST) begin
                m_init[i]   = 1'b1;
                m_active[i] = 1'b0;
                m_last[i]   = 1'b1;
                m_log[i]    = 16'h0000;
                m_resp[i]   = 16'h0000;
            end else if (m_init[i]) begin
                m_init[i] = 1'b0;
            end else if (m_active[i]) begin
                if (cyc == m_done[i]) begin
                    m_resp[i] = m_log[i] + 16'd1;
                    m_pulse[i][m_owner[i]] = 1'b1;
                    m_active[i] = 1'b0;
                    rsp_c[i][n_rsp[i] % 1024] = cyc;
                    rsp_o[i][n_rsp[i] % 1024] = m_owner[i];
                    rsp_d[i][n_rsp[i] % 1024] = m_resp[i];
                    n_rsp[i]++;
                end
            end else if (a != 2'b00) begin
                m_owner[i]  = a[1];
                m_last[i]   = a[1];
                m_log[i]    = dat[i][a[1]];
                m_active[i] = 1'b1;
                m_done[i]   = cyc + wc(i) + 1;
                acc_c[i][n_acc[i] % 1024] = cyc;
                acc_o[i][n_acc[i] % 1024] = a[1];
                n_acc[i]++;
            end
        end
        started = 1'b1;
    end

    always @(negedge CLK) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready", i, 16'(rdy[i]), 16'(exp_rdy(i)));
                chk("busy", i, 16'(bsy[i]), 16'(m_init[i] | m_active[i]));
                chk("resp_valid", i, 16'(rsp[i]), 16'(m_pulse[i]));
                chk("resp_data", i, rdata[i], m_resp[i]);
                chk("log_data", i, ldata[i], m_log[i]);
            end
        end
    end

    // Requester FIFOs: valid stays up with the head operand until it is accepted.
    logic [15:0] fifo [2][2][256];
    int          wr   [2][2];
    int          rd   [2][2];

    task automatic push(input int i, input int j, input logic [15:0] d);
        fifo[i][j][wr[i][j] % 256] = d;
        wr[i][j]++;
    endtask

    task automatic step();
        logic [1:0] took [2];
        @(negedge CLK);
        for (int i = 0; i < 2; i++) took[i] = vld[i] & rdy[i];
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (took[i][j]) rd[i][j]++;
                vld[i][j] = (rd[i][j] != wr[i][j]);
                dat[i][j] = fifo[i][j][rd[i][j] % 256];
            end
        end
    endtask

    task automatic wait_rsp(input int i, input int target, input int limit);
        int k = 0;
        while (n_rsp[i] < target && k < limit) begin
            step();
            k++;
        end
        chk("rsp_timeout", i, 16'(n_rsp[i]), 16'(target));
    endtask

    initial begin
        int b_a;
        int b_r;
        int k;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 2'b00;
            for (int j = 0; j < 2; j++) begin
                dat[i][j] = 16'h0000;
                wr[i][j]  = 0;
                rd[i][j]  = 0;
            end
        end

        // Reset and the single INIT cycle.
        repeat (3) step();
        chk("rst_resp_data", 0, rdata[0], 16'h0000);
        chk("rst_log_data", 0, ldata[0], 16'h0000);
        chk("rst_resp_valid", 0, 16'(rsp[0]), 16'h0000);
        chk("rst_ready", 0, 16'(rdy[0]), 16'h0000);
        RST = 1'b0;
        #1;
        chk("init_busy", 0, 16'(bsy[0]), 16'h0001);
        chk("init_ready", 0, 16'(rdy[0]), 16'h0000);
        step();
        chk("idle_busy", 0, 16'(bsy[0]), 16'h0000);

        // Single request.
        b_a = n_acc[0];
        b_r = n_rsp[0];
        push(0, 0, 16'h0200);
        wait_rsp(0, b_r + 1, 20);
        chk("single_owner", 0, 16'(rsp_o[0][b_r]), 16'h0000);
        chk("single_data", 0, rsp_d[0][b_r], 16'h0201);
        chk("single_latency", 0, 16'(rsp_c[0][b_r] - acc_c[0][b_a]), 16'd4);
        chk("single_dut_data", 0, rdata[0], 16'h0201);
        chk("single_dut_log", 0, ldata[0], 16'h0200);

        // Contention straight out of reset: requester 0 wins first.
        RST = 1'b1;
        push(0, 0, 16'h0100);
        push(0, 1, 16'h0300);
        step();
        step();
        RST = 1'b0;
        b_a = n_acc[0];
        b_r = n_rsp[0];
        wait_rsp(0, b_r + 2, 30);
        chk("cont_first_owner", 0, 16'(rsp_o[0][b_r]), 16'h0000);
        chk("cont_first_data", 0, rsp_d[0][b_r], 16'h0101);
        chk("cont_second_owner", 0, 16'(rsp_o[0][b_r + 1]), 16'h0001);
        chk("cont_second_data", 0, rsp_d[0][b_r + 1], 16'h0301);
        chk("cont_b2b_accept", 0, 16'(acc_c[0][b_a + 1] - rsp_c[0][b_r]), 16'd1);

        // Fairness under continuous contention.
        b_a = n_acc[0];
        b_r = n_rsp[0];
        for (int m = 0; m < 3; m++) begin
            push(0, 0, 16'h1000 + 16'(m));
            push(0, 1, 16'h2000 + 16'(m));
        end
        wait_rsp(0, b_r + 6, 60);
        for (int m = 0; m < 6; m++) begin
            chk("fair_owner", 0, 16'(acc_o[0][b_a + m]), 16'(m % 2));
            if (m > 0) chk("fair_interval", 0, 16'(rsp_c[0][b_r + m] - rsp_c[0][b_r + m - 1]), 16'd5);
        end

        // Reset during WAIT aborts without a response.
        b_a = n_acc[0];
        b_r = n_rsp[0];
        push(0, 1, 16'h0444);
        k = 0;
        while (n_acc[0] == b_a && k < 20) begin
            step();
            k++;
        end
        chk("abort_accepted", 0, 16'(n_acc[0]), 16'(b_a + 1));
        step();
        RST = 1'b1;
        step();
        chk("abort_resp_data", 0, rdata[0], 16'h0000);
        chk("abort_busy_init", 0, 16'(bsy[0]), 16'h0001);
        RST = 1'b0;
        repeat (4) step();
        chk("abort_no_pulse", 0, 16'(n_rsp[0]), 16'(b_r));
        push(0, 0, 16'h0010);
        wait_rsp(0, b_r + 1, 20);
        chk("abort_fresh_data", 0, rdata[0], 16'h0011);
        chk("abort_fresh_owner", 0, 16'(rsp_o[0][b_r]), 16'h0000);

        // N_STAGE=4 instance: six edges from accept to response.
        b_a = n_acc[1];
        b_r = n_rsp[1];
        push(1, 0, 16'h0777);
        wait_rsp(1, b_r + 1, 30);
        chk("sweep_latency", 1, 16'(rsp_c[1][b_r] - acc_c[1][b_a]), 16'd6);
        chk("sweep_data", 1, rdata[1], 16'h0778);

        // Random traffic on both instances with occasional resets.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if ((wr[i][j] - rd[i][j]) < 3 && $urandom_range(0, 3) == 0)
                        push(i, j, 16'($urandom));
                end
            end
            RST = ($urandom_range(0, 99) == 0);
            step();
        end
        RST = 1'b0;
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
